// File: rtl/ibus_mem_responder_pkg.sv
// Shared packages for the instruction bus: memory width defaults (common) and
// fetch/responder transaction types (pipes).
package common;
  localparam int MEM_DW = 64;
  localparam int MEM_AW = 64;
endpackage

package pipes;
  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    RESP,
    DRAIN
  } ibus_resp_state_t;

  localparam logic [63:0] IBUS_RESET_PC = 64'h8000_0000;

  function automatic logic ibus_misaligned(input logic [1:0] addr_lsb);
    return addr_lsb != 2'b00;
  endfunction
endpackage

// File: rtl/ibus_mem_responder_linebuf.sv
// ibus_linebuf: one-entry memory-word buffer with tag compare, present only
// when IBUS_LINEBUF_EN is defined.
`ifdef IBUS_LINEBUF_EN
module ibus_linebuf #(
  parameter int MEM_DW = 64,
  parameter int TAG_W  = 61
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fill,
  input  logic [TAG_W-1:0]  tag,
  input  logic [MEM_DW-1:0] fill_word,
  output logic              hit,
  output logic [MEM_DW-1:0] word
);
  logic              valid_q;
  logic [TAG_W-1:0]  tag_q;
  logic [MEM_DW-1:0] word_q;

  // Only reset clears the entry; every completed fetch overwrites it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      word_q  <= '0;
    end else if (fill) begin
      valid_q <= 1'b1;
      tag_q   <= tag;
      word_q  <= fill_word;
    end
  end

  assign hit  = valid_q && (tag_q == tag);
  assign word = word_q;
endmodule
`endif

// File: rtl/ibus_mem_responder.sv
// ibus_mem_responder: fetch-side responder driving a req/gnt/rvalid memory port.
// Define IBUS_LINEBUF_EN to add a one-entry line buffer in front of memory.
//
// state | meaning
// IDLE  | waiting for ireq.valid; addr_ok_q high marks the accept cycle
// REQ   | mem_req held with aligned address until mem_gnt
// WAIT  | granted, waiting for mem_rvalid
// RESP  | one-cycle data_ok with selected instruction (or fault)
// DRAIN | fetch withdrew; finish the memory handshake and discard data
module ibus_mem_responder
  import pipes::*;
#(
  parameter int MEM_DW = common::MEM_DW,
  parameter int MEM_AW = common::MEM_AW
) (
  input  logic              clk,
  input  logic              reset,
  input  ibus_req_t         ireq,
  output ibus_resp_t        iresp,
  output logic              ifault,
  output logic              mem_req,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [MEM_DW-1:0] mem_rdata
);
  localparam int OFFS = $clog2(MEM_DW / 8);
  localparam int TAG_W = 64 - OFFS;
  localparam logic [MEM_AW-1:0] ALIGN_MASK = ~MEM_AW'(MEM_DW / 8 - 1);

  ibus_resp_state_t state, state_d;

  logic [63:0]       a_q;
  logic              owed_q, owed_d;
  logic              addr_ok_q, addr_ok_d;
  logic              data_ok_q, data_ok_d;
  logic              ifault_q, ifault_d;
  logic              mem_req_q, mem_req_d;
  logic [31:0]       data_q, data_d;
  logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;

  logic        withdraw;
  logic        misaligned;
  logic        lb_hit;
  logic [31:0] rd_lane;
  logic [31:0] lb_lane;

  assign withdraw   = !ireq.valid || (ireq.addr != a_q);
  assign misaligned = ibus_misaligned(a_q[1:0]);

  if (MEM_DW == 64) begin : g_rd_lane64
    assign rd_lane = a_q[2] ? mem_rdata[63:32] : mem_rdata[31:0];
  end else begin : g_rd_lane32
    assign rd_lane = mem_rdata[31:0];
  end

`ifdef IBUS_LINEBUF_EN
  logic              lb_fill;
  logic [MEM_DW-1:0] lb_word;

  assign lb_fill = (state == WAIT) && mem_rvalid && !withdraw;

  ibus_linebuf #(
    .MEM_DW(MEM_DW),
    .TAG_W (TAG_W)
  ) u_linebuf (
    .clk      (clk),
    .reset    (reset),
    .fill     (lb_fill),
    .tag      (a_q[63:OFFS]),
    .fill_word(mem_rdata),
    .hit      (lb_hit),
    .word     (lb_word)
  );

  if (MEM_DW == 64) begin : g_lb_lane64
    assign lb_lane = a_q[2] ? lb_word[63:32] : lb_word[31:0];
  end else begin : g_lb_lane32
    assign lb_lane = lb_word[31:0];
  end
`else
  assign lb_hit  = 1'b0;
  assign lb_lane = '0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    owed_d  = owed_q;
    case (state)
      IDLE: begin
        if (addr_ok_q) begin
          state_d = (misaligned || lb_hit) ? RESP : REQ;
        end
      end
      REQ: begin
        if (withdraw) begin
          state_d = DRAIN;
          owed_d  = !mem_gnt;
        end else if (mem_gnt) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        // A withdrawal beats a same-cycle rvalid: the data is simply dropped.
        if (withdraw) begin
          state_d = mem_rvalid ? IDLE : DRAIN;
          owed_d  = 1'b0;
        end else if (mem_rvalid) begin
          state_d = RESP;
        end
      end
      RESP: state_d = IDLE;
      DRAIN: begin
        if (owed_q) begin
          if (mem_gnt) owed_d = 1'b0;
        end else if (mem_rvalid) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    addr_ok_d  = (state == IDLE) && !addr_ok_q && ireq.valid;
    mem_req_d  = (state_d == REQ) || ((state_d == DRAIN) && owed_d);
    mem_addr_d = mem_addr_q;
    if ((state == IDLE) && (state_d == REQ)) begin
      mem_addr_d = a_q[MEM_AW-1:0] & ALIGN_MASK;
    end
    data_ok_d = (state_d == RESP);
    ifault_d  = (state_d == RESP) && misaligned;
    data_d    = '0;
    if ((state_d == RESP) && !misaligned) begin
      data_d = (state == IDLE) ? lb_lane : rd_lane;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q        <= '0;
      owed_q     <= 1'b0;
      addr_ok_q  <= 1'b0;
      data_ok_q  <= 1'b0;
      ifault_q   <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      data_q     <= '0;
    end else begin
      if (addr_ok_d) a_q <= ireq.addr;
      owed_q     <= owed_d;
      addr_ok_q  <= addr_ok_d;
      data_ok_q  <= data_ok_d;
      ifault_q   <= ifault_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      data_q     <= data_d;
    end
  end

  assign iresp    = '{addr_ok: addr_ok_q, data_ok: data_ok_q, data: data_q};
  assign ifault   = ifault_q;
  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
endmodule

// File: tb/tb_ibus_mem_responder.sv
// Directed bench for ibus_mem_responder; the final step adapts to IBUS_LINEBUF_EN.
module tb_ibus_mem_responder;
  import pipes::*;

  logic        clk = 1'b0;
  logic        reset;
  ibus_req_t   ireq;
  ibus_resp_t  iresp;
  logic        ifault;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;

  int checks = 0;
  int failures = 0;

  ibus_mem_responder #(.MEM_DW(64), .MEM_AW(64)) dut (
    .clk       (clk),
    .reset     (reset),
    .ireq      (ireq),
    .iresp     (iresp),
    .ifault    (ifault),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_gnt   (mem_gnt),
    .mem_rvalid(mem_rvalid),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset      = 1'b1;
    ireq       = '0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    tick();
    tick();
    chk("rst_addr_ok", iresp.addr_ok, 0);
    chk("rst_data_ok", iresp.data_ok, 0);
    chk("rst_data", iresp.data, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    reset = 1'b0;

    // basic fetch, upper lane
    ireq = '{valid: 1'b1, addr: IBUS_RESET_PC + 64'h4};
    tick();
    chk("b_addr_ok", iresp.addr_ok, 1);
    chk("b_req_early", mem_req, 0);
    tick();
    chk("b_addr_ok_pulse", iresp.addr_ok, 0);
    chk("b_mem_req", mem_req, 1);
    chk("b_mem_addr", mem_addr, 64'h8000_0000);
    mem_gnt = 1'b1;
    tick();
    chk("b_req_drop", mem_req, 0);
    chk("b_no_early_data", iresp.data_ok, 0);
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 64'h0000_0013_0010_0093;
    tick();
    chk("b_data_ok", iresp.data_ok, 1);
    chk("b_data", iresp.data, 32'h0000_0013);
    chk("b_ifault", ifault, 0);
    chk("b_no_addr_ok", iresp.addr_ok, 0);
    mem_rvalid = 1'b0;
    ireq.valid = 1'b0;
    tick();
    chk("b_data_ok_once", iresp.data_ok, 0);

    // stalled memory, lower lane
    ireq = '{valid: 1'b1, addr: 64'h8000_0008};
    tick();
    chk("s_addr_ok", iresp.addr_ok, 1);
    tick();
    chk("s_mem_req", mem_req, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("s_req_hold", mem_req, 1);
      chk("s_addr_hold", mem_addr, 64'h8000_0008);
    end
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    chk("s_req_drop", mem_req, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("s_wait_no_data", iresp.data_ok, 0);
    end
    mem_rvalid = 1'b1;
    mem_rdata  = 64'hAAAA_BBBB_CCCC_DDDD;
    tick();
    mem_rvalid = 1'b0;
    chk("s_data_ok", iresp.data_ok, 1);
    chk("s_data", iresp.data, 32'hCCCC_DDDD);
    ireq.valid = 1'b0;
    tick();
    chk("s_data_ok_once", iresp.data_ok, 0);

    // branch redirect during WAIT
    ireq = '{valid: 1'b1, addr: 64'h8000_0010};
    tick();
    tick();
    chk("w_mem_addr", mem_addr, 64'h8000_0010);
    mem_gnt = 1'b1;
    tick();
    mem_gnt   = 1'b0;
    ireq.addr = 64'h8000_0100;
    tick();
    chk("w_drain_no_data", iresp.data_ok, 0);
    chk("w_drain_no_req", mem_req, 0);
    mem_rvalid = 1'b1;
    mem_rdata  = 64'h1111_1111_2222_2222;
    tick();
    mem_rvalid = 1'b0;
    chk("w_discard", iresp.data_ok, 0);
    tick();
    chk("w_new_addr_ok", iresp.addr_ok, 1);
    tick();
    chk("w_new_req", mem_req, 1);
    chk("w_new_mem_addr", mem_addr, 64'h8000_0100);
    mem_gnt = 1'b1;
    tick();
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 64'h3333_3333_4444_4444;
    tick();
    mem_rvalid = 1'b0;
    chk("w_new_data_ok", iresp.data_ok, 1);
    chk("w_new_data", iresp.data, 32'h4444_4444);
    ireq.valid = 1'b0;
    tick();

    // withdrawal in REQ before grant: request held until the owed gnt
    ireq = '{valid: 1'b1, addr: 64'h8000_0020};
    tick();
    tick();
    ireq.valid = 1'b0;
    tick();
    chk("d_req_owed", mem_req, 1);
    chk("d_addr_owed", mem_addr, 64'h8000_0020);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    chk("d_req_done", mem_req, 0);
    mem_rvalid = 1'b1;
    tick();
    mem_rvalid = 1'b0;
    chk("d_no_data", iresp.data_ok, 0);
    tick();
    chk("d_idle_no_addr_ok", iresp.addr_ok, 0);

    // misaligned
    ireq = '{valid: 1'b1, addr: 64'h8000_0002};
    tick();
    chk("m_addr_ok", iresp.addr_ok, 1);
    tick();
    chk("m_data_ok", iresp.data_ok, 1);
    chk("m_data", iresp.data, 0);
    chk("m_ifault", ifault, 1);
    chk("m_no_req", mem_req, 0);
    ireq.valid = 1'b0;
    tick();
    chk("m_ifault_pulse", ifault, 0);
    chk("m_no_req_after", mem_req, 0);

    // async reset mid-WAIT
    ireq = '{valid: 1'b1, addr: IBUS_RESET_PC};
    tick();
    tick();
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    chk("r_pre_addr", mem_addr, 64'h8000_0000);
    #2;
    reset = 1'b1;
    #1;
    chk("r_async_addr", mem_addr, 0);
    chk("r_async_req", mem_req, 0);
    chk("r_async_data_ok", iresp.data_ok, 0);
    tick();
    reset = 1'b0;
    tick();
    chk("r_addr_ok", iresp.addr_ok, 1);
    tick();
    chk("r_mem_req", mem_req, 1);
    chk("r_mem_addr", mem_addr, 64'h8000_0000);
    mem_gnt = 1'b1;
    tick();
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 64'hDEAD_BEEF_CAFE_F00D;
    tick();
    mem_rvalid = 1'b0;
    chk("r_data_ok", iresp.data_ok, 1);
    chk("r_data", iresp.data, 32'hCAFE_F00D);
    ireq.valid = 1'b0;
    tick();

    // same memory word, upper lane
    ireq = '{valid: 1'b1, addr: IBUS_RESET_PC + 64'h4};
    tick();
    chk("h_addr_ok", iresp.addr_ok, 1);
    tick();
`ifdef IBUS_LINEBUF_EN
    chk("h_data_ok", iresp.data_ok, 1);
    chk("h_data", iresp.data, 32'hDEAD_BEEF);
    chk("h_no_req", mem_req, 0);
`else
    chk("h_miss_req", mem_req, 1);
    chk("h_miss_no_data", iresp.data_ok, 0);
    mem_gnt = 1'b1;
    tick();
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 64'h0123_4567_89AB_CDEF;
    tick();
    mem_rvalid = 1'b0;
    chk("h_miss_data_ok", iresp.data_ok, 1);
    chk("h_miss_data", iresp.data, 32'h0123_4567);
`endif
    ireq.valid = 1'b0;
    tick();
    chk("h_data_ok_once", iresp.data_ok, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ibus_mem_responder.md
Name: ibus_mem_responder

Overview:
- Responder end of the instruction bus: accepts `ibus_req_t` from the fetch stage and returns `ibus_resp_t`.
- Services each request through a simple request/grant/rvalid read port on a MEM_DW-wide instruction memory.
- Extracts the addressed 32-bit instruction and handles requests withdrawn on branch redirects.
- Sits between fetch and the instruction memory/cache.

Parameters:
- MEM_DW, 64, memory word width in bits (64 or 32).
- MEM_AW, 64, memory address width in bits.

Ports:
- clk  in  1  clock; single clock domain.
- reset  in  1  asynchronous, active-high reset.
- ireq  in  ibus_req_t  {valid, addr[63:0]}; level request from fetch.
- iresp  out  ibus_resp_t  {addr_ok, data_ok, data[31:0]}.
- ifault  out  1  pulses with data_ok when the request was misaligned.
- mem_req  out  1  memory read request.
- mem_addr  out  MEM_AW  MEM_DW/8-aligned word address.
- mem_gnt  in  1  memory accepted mem_req this cycle.
- mem_rvalid  in  1  read data valid; never in the same cycle as its mem_gnt.
- mem_rdata  in  MEM_DW  read data.

Behaviour:
- Reset (async, immediate): state=IDLE; iresp.addr_ok=0, data_ok=0, data=0; ifault=0; mem_req=0; mem_addr=0; captured address cleared; line buffer invalid. A memory transaction in flight at reset is abandoned; memory must tolerate a dropped mem_req.
- All outputs are registered from state; there are no combinational paths from ireq to mem_*.
- FSM states: IDLE, REQ, WAIT, RESP, DRAIN.
  - IDLE: when ireq.valid=1, accept: addr_ok=1 for one cycle and capture addr into A.
    - If A[1:0]!=0, go to RESP with data=0, ifault=1 and no memory access.
    - Otherwise go to REQ.
  - REQ: mem_req=1, mem_addr=A with the low log2(MEM_DW/8) bits zeroed. Hold mem_req and mem_addr stable until mem_gnt. On gnt go to WAIT.
  - WAIT: on mem_rvalid, select the 32-bit lane and go to RESP.
    - MEM_DW=64: lane = A[2] ? rdata[63:32] : rdata[31:0].
    - MEM_DW=32: lane = rdata.
  - RESP: data_ok=1 with data for exactly one cycle, then IDLE. A new request is not accepted in the RESP cycle.
  - DRAIN: the transaction was withdrawn. Finish the memory handshake (gnt if still in REQ, then rvalid), discard the data, go to IDLE. No data_ok is issued.
- Withdrawal: in REQ or WAIT, if ireq.valid=0 or ireq.addr!=A, move to DRAIN. DRAIN keeps the pending REQ/WAIT obligation (a 1-bit flag records whether gnt is still owed).
- Withdrawal and rvalid in the same cycle: the withdrawal wins; data is discarded and the next state is IDLE.
- Minimum latency, gnt in the REQ cycle and rvalid one cycle later: accept at N, REQ at N+1, WAIT at N+2, data_ok at N+3.
- data_ok and addr_ok are never high in the same cycle.
- At most one outstanding memory transaction.

Optional Feature:
- Macro: IBUS_LINEBUF_EN.
- Defined: a one-entry line buffer holds {valid, tag=A[63:log2(MEM_DW/8)], word}, filled on every completed (non-drained) rvalid.
  - At IDLE acceptance, an aligned request whose tag matches a valid entry goes straight to RESP. data_ok is at N+1 and there is no memory access.
  - The entry is invalidated on reset only.
- Undefined: no buffer; every aligned request goes to memory.

Decomposition:
- Shared package `pipes`: `ibus_req_t`, `ibus_resp_t` (already in use), `ibus_resp_state_t` enum {IDLE, REQ, WAIT, RESP, DRAIN}, and a constant `IBUS_RESET_PC` = 64'h80000000 for benches.
- Shared package `common`: `MEM_DW` default.
- Natural sub-module: `ibus_linebuf`, holding the tag/word/valid storage and the hit compare, instantiated only under IBUS_LINEBUF_EN.

Test Plan:
- Basic fetch: valid, addr=0x80000004; mem gnt immediate, rvalid next cycle with rdata=0x00000013_00100093 → addr_ok at N, mem_addr=0x80000000, data_ok at N+3 with data=0x00000013, ifault=0.
- Stalled memory: gnt delayed 3 cycles, rvalid 5 cycles after gnt → mem_req and mem_addr held stable throughout, exactly one data_ok, data lane selected by A[2].
- Branch withdrawal: addr changes 0x80000010→0x80000100 during WAIT → no data_ok for 0x80000010; after rvalid, IDLE accepts 0x80000100 and returns its data.
- Misaligned: addr=0x80000002 → addr_ok, then data_ok next cycle with data=0 and ifault=1, mem_req never asserted.
- Async reset asserted mid-WAIT → all outputs 0 immediately; after release, request 0x80000000 completes normally.
- IBUS_LINEBUF_EN defined: fetch 0x80000000 then 0x80000004 → second request gets data_ok one cycle after accept with rdata[63:32] and no mem_req.
